hazard_ctl: RTL and testbench

HAZARD_CTL -- requirements
Module: hazard_ctl

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_fwd_sel.sv | 30 +++
 rtl/hazard_ctl.sv | 168 ++++++++++++++++
 tb/tb_hazard_ctl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states,
// forwarding selects and the result/PC source codes it decodes.
package hazard_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_WAIT       = 2'd1,
        ST_WAIT_FLUSH = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
    localparam logic [1:0] PC_SRC_SEQ     = 2'b00;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding-source select for one EX-stage operand; the MEM stage wins
// over WB because it holds the younger result.
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [REG_AW-1:0] i_rs_e,
    input  logic [REG_AW-1:0] i_rd_m,
    input  logic              i_reg_write_m,
    input  logic [REG_AW-1:0] i_rd_w,
    input  logic              i_reg_write_w,
    output logic [1:0]        o_fwd
);

    logic w_hit_m;
    logic w_hit_w;

    // x0 is hard-wired, so a write to it never produces a forward
    assign w_hit_m = i_reg_write_m && (i_rd_m != '0) && (i_rd_m == i_rs_e);
    assign w_hit_w = i_reg_write_w && (i_rd_w != '0) && (i_rd_w == i_rs_e);

    always_comb begin
        o_fwd = FWD_NONE;
        if (w_hit_m) begin
            o_fwd = FWD_MEM;
        end else if (w_hit_w) begin
            o_fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: operand forwarding, load-use stalls, redirect
// flushes and instruction-fetch wait handling. Define HAZARD_CTL_PERF_EN to
// add saturating stall/flush performance counters.
module hazard_ctl
    import hazard_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clk_en,
    input  logic [REG_AW-1:0] i_rs1_d,
    input  logic [REG_AW-1:0] i_rs2_d,
    input  logic [REG_AW-1:0] i_rs1_e,
    input  logic [REG_AW-1:0] i_rs2_e,
    input  logic [REG_AW-1:0] i_rd_e,
    input  logic [1:0]        i_result_src_e,
    input  logic [REG_AW-1:0] i_rd_m,
    input  logic              i_reg_write_m,
    input  logic [REG_AW-1:0] i_rd_w,
    input  logic              i_reg_write_w,
    input  logic [1:0]        i_pc_src_e,
    input  logic              i_imem_ready,
    output logic              o_pc_wr_en_h,
    output logic              o_if_id_stall_h,
    output logic              o_if_id_flush_h,
    output logic              o_id_ex_flush_h,
    output logic [1:0]        o_fwd_a_e,
    output logic [1:0]        o_fwd_b_e
`ifdef HAZARD_CTL_PERF_EN
    ,
    output logic [31:0]       o_stall_cnt,
    output logic [31:0]       o_flush_cnt
`endif
);

    hz_state_e  r_state;
    hz_state_e  w_state_nxt;
    logic       w_redirect;
    logic       w_load_use;
    logic       w_pc_wr_en;
    logic       w_if_id_stall;
    logic       w_if_id_flush;
    logic       w_id_ex_flush;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    hazard_fwd_sel u_fwd_a (
        .i_rs_e        (i_rs1_e),
        .i_rd_m        (i_rd_m),
        .i_reg_write_m (i_reg_write_m),
        .i_rd_w        (i_rd_w),
        .i_reg_write_w (i_reg_write_w),
        .o_fwd         (w_fwd_a)
    );

    hazard_fwd_sel u_fwd_b (
        .i_rs_e        (i_rs2_e),
        .i_rd_m        (i_rd_m),
        .i_reg_write_m (i_reg_write_m),
        .i_rd_w        (i_rd_w),
        .i_reg_write_w (i_reg_write_w),
        .o_fwd         (w_fwd_b)
    );

    assign w_redirect = (i_pc_src_e != PC_SRC_SEQ);
    assign w_load_use = (i_result_src_e == RESULT_SRC_MEM) && (i_rd_e != '0) &&
                        ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_RUN;
        end else if (i_clk_en) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_wr_en    = 1'b1;
        w_if_id_stall = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;

        // Fetch-wait behaviour first; load-use and redirect override below
        case (r_state)
            ST_RUN: begin
                if (!i_imem_ready) begin
                    w_state_nxt   = w_redirect ? ST_WAIT_FLUSH : ST_WAIT;
                    w_pc_wr_en    = 1'b0;
                    w_if_id_flush = 1'b1;
                end
            end
            ST_WAIT: begin
                if (w_redirect) begin
                    w_state_nxt = ST_WAIT_FLUSH;
                end else if (i_imem_ready) begin
                    w_state_nxt = ST_RUN;
                end
                if (!i_imem_ready) begin
                    w_pc_wr_en    = 1'b0;
                    w_if_id_flush = 1'b1;
                end
            end
            ST_WAIT_FLUSH: begin
                // The fetch in flight belongs to the old path; drop it even
                // on the cycle it finally arrives.
                w_pc_wr_en    = 1'b0;
                w_if_id_flush = 1'b1;
                if (i_imem_ready) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        if (w_load_use) begin
            w_pc_wr_en    = 1'b0;
            w_if_id_stall = 1'b1;
            w_if_id_flush = (r_state == ST_WAIT_FLUSH);
            w_id_ex_flush = 1'b1;
        end

        if (w_redirect) begin
            w_pc_wr_en    = 1'b1;
            w_if_id_stall = 1'b0;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end

        if (i_rst) begin
            w_pc_wr_en    = 1'b1;
            w_if_id_stall = 1'b0;
            w_if_id_flush = 1'b0;
            w_id_ex_flush = 1'b0;
        end
    end

    assign o_pc_wr_en_h    = w_pc_wr_en;
    assign o_if_id_stall_h = w_if_id_stall;
    assign o_if_id_flush_h = w_if_id_flush;
    assign o_id_ex_flush_h = w_id_ex_flush;
    assign o_fwd_a_e       = i_rst ? FWD_NONE : w_fwd_a;
    assign o_fwd_b_e       = i_rst ? FWD_NONE : w_fwd_b;

`ifdef HAZARD_CTL_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (i_clk_en) begin
            if (!w_pc_wr_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_id_ex_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// Self-checking bench for hazard_ctl: directed scenarios plus randomized
// traffic compared against a flag-based behavioural model.
module tb_hazard_ctl;

    logic       clk = 1'b0;
    logic       rst, clk_en;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0] result_src_e, pc_src_e;
    logic       reg_write_m, reg_write_w, imem_ready;
    logic       pc_wr_en, if_id_stall, if_id_flush, id_ex_flush;
    logic [1:0] fwd_a, fwd_b;
    logic [7:0] obs;
    logic [3:0] ctl;
`ifdef HAZARD_CTL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Model: "waiting" = fetch outstanding, "stale" = outstanding fetch must be dropped
    bit          m_wait  = 1'b0;
    bit          m_stale = 1'b0;
    logic [31:0] m_stall_cnt = '0;
    logic [31:0] m_flush_cnt = '0;

    always #5 clk = ~clk;

    hazard_ctl dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_clk_en        (clk_en),
        .i_rs1_d         (rs1_d),
        .i_rs2_d         (rs2_d),
        .i_rs1_e         (rs1_e),
        .i_rs2_e         (rs2_e),
        .i_rd_e          (rd_e),
        .i_result_src_e  (result_src_e),
        .i_rd_m          (rd_m),
        .i_reg_write_m   (reg_write_m),
        .i_rd_w          (rd_w),
        .i_reg_write_w   (reg_write_w),
        .i_pc_src_e      (pc_src_e),
        .i_imem_ready    (imem_ready),
        .o_pc_wr_en_h    (pc_wr_en),
        .o_if_id_stall_h (if_id_stall),
        .o_if_id_flush_h (if_id_flush),
        .o_id_ex_flush_h (id_ex_flush),
        .o_fwd_a_e       (fwd_a),
        .o_fwd_b_e       (fwd_b)
`ifdef HAZARD_CTL_PERF_EN
        ,
        .o_stall_cnt     (stall_cnt),
        .o_flush_cnt     (flush_cnt)
`endif
    );

    assign ctl = {pc_wr_en, if_id_stall, if_id_flush, id_ex_flush};
    assign obs = {ctl, fwd_a, fwd_b};

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (rst) return 2'b00;
        if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    // {pc_wr_en, if_id_stall, if_id_flush, id_ex_flush}
    function automatic logic [3:0] ref_ctl();
        bit redirect, lu;
        redirect = (pc_src_e != 2'b00);
        lu = (result_src_e == 2'b01) && (rd_e != 0) && (rd_e == rs1_d || rd_e == rs2_d);
        if (rst)          return 4'b1000;
        if (redirect)     return 4'b1011;
        if (lu)           return {3'b010, 1'b1} | {2'b00, m_stale, 1'b0};
        if (m_stale)      return 4'b0010;
        if (!imem_ready)  return 4'b0010;
        return 4'b1000;
    endfunction

    function automatic logic [7:0] ref_all();
        return {ref_ctl(), ref_fwd(rs1_e), ref_fwd(rs2_e)};
    endfunction

    task automatic model_async_reset();
        m_wait = 1'b0; m_stale = 1'b0; m_stall_cnt = '0; m_flush_cnt = '0;
    endtask

    // Advance one clock; inputs are held stable across the edge
    task automatic tick();
        logic [3:0]  c;
        bit          nw, ns;
        logic [31:0] nsc, nfc;
        c = ref_ctl();
        nw = m_wait; ns = m_stale; nsc = m_stall_cnt; nfc = m_flush_cnt;
        if (rst) begin
            nw = 1'b0; ns = 1'b0; nsc = '0; nfc = '0;
        end else if (clk_en) begin
            if (m_stale) ns = !imem_ready;
            else if (pc_src_e != 0 && (m_wait || !imem_ready)) begin ns = 1'b1; nw = 1'b0; end
            else nw = !imem_ready;
            if (!c[3] && nsc != 32'hFFFFFFFF) nsc = nsc + 1;
            if (c[0] && nfc != 32'hFFFFFFFF) nfc = nfc + 1;
        end
        @(posedge clk);
        m_wait = nw; m_stale = ns; m_stall_cnt = nsc; m_flush_cnt = nfc;
        @(negedge clk);
    endtask

    task automatic set_idle();
        rst = 1'b0; clk_en = 1'b1; imem_ready = 1'b1;
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        result_src_e = 2'b00; pc_src_e = 2'b00; reg_write_m = 1'b0; reg_write_w = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1; imem_ready = 1'b0; pc_src_e = 2'b01;
        reg_write_m = 1'b1; rd_m = 3; rs1_e = 3; result_src_e = 2'b01; rd_e = 2; rs1_d = 2;
        #1;
        checks++;
        if (obs !== 8'b1000_0000) begin
            errors++; $display("FAIL reset_outputs: got %b expected %b", obs, 8'b1000_0000);
        end
        tick();
        #1;
        checks++;
        if (obs !== 8'b1000_0000) begin
            errors++; $display("FAIL reset_held: got %b expected %b", obs, 8'b1000_0000);
        end
`ifdef HAZARD_CTL_PERF_EN
        checks++;
        if (stall_cnt !== 0 || flush_cnt !== 0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
`endif
        set_idle();
        tick();
    endtask

    task automatic test_forwarding();
        set_idle();
        rd_m = 5; reg_write_m = 1'b1; rd_w = 5; reg_write_w = 1'b1; rs1_e = 5;
        #1;
        checks++;
        if (fwd_a !== 2'b10) begin
            errors++; $display("FAIL fwd_mem_priority: got %b expected 10", fwd_a);
        end
        rd_m = 0; rs2_e = 5;
        #1;
        checks++;
        if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
            errors++; $display("FAIL fwd_wb_when_rdm0: got a=%b b=%b expected 01/01", fwd_a, fwd_b);
        end
        for (int i = 0; i < 40; i++) begin
            rd_m = 5'($urandom_range(0, 3)); rd_w = 5'($urandom_range(0, 3));
            rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
            reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
            #1;
            checks++;
            if ({fwd_a, fwd_b} !== {ref_fwd(rs1_e), ref_fwd(rs2_e)}) begin
                errors++; $display("FAIL fwd_random: got %b expected %b", {fwd_a, fwd_b},
                                   {ref_fwd(rs1_e), ref_fwd(rs2_e)});
            end
        end
        set_idle();
        tick();
    endtask

    task automatic test_load_use();
        set_idle();
        result_src_e = 2'b01; rd_e = 7; rs2_d = 7;
        #1;
        checks++;
        if (ctl !== 4'b0101) begin
            errors++; $display("FAIL load_use_stall: got %b expected 0101", ctl);
        end
        tick();
        result_src_e = 2'b00; rd_e = 0; rs2_d = 0;
        #1;
        checks++;
        if (ctl !== 4'b1000) begin
            errors++; $display("FAIL load_use_release: got %b expected 1000", ctl);
        end
        result_src_e = 2'b01; rd_e = 0; rs2_d = 0;
        #1;
        checks++;
        if (ctl !== 4'b1000) begin
            errors++; $display("FAIL load_use_x0: got %b expected 1000", ctl);
        end
        tick();
        set_idle();
    endtask

    task automatic test_fetch_wait();
        set_idle();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== 4'b0010) begin
                errors++; $display("FAIL fetch_wait_cycle%0d: got %b expected 0010", i, ctl);
            end
            tick();
        end
        imem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== 4'b1000) begin
            errors++; $display("FAIL fetch_wait_ready: got %b expected 1000", ctl);
        end
        tick();
        #1;
        checks++;
        if (ctl !== 4'b1000) begin
            errors++; $display("FAIL fetch_wait_run: got %b expected 1000", ctl);
        end
    endtask

    task automatic test_redirect_in_wait();
        set_idle();
        imem_ready = 1'b0;
        #1;
        tick();
        pc_src_e = 2'b01;
        #1;
        checks++;
        if (ctl !== 4'b1011) begin
            errors++; $display("FAIL rdr_wait_c1: got %b expected 1011", ctl);
        end
        tick();
        pc_src_e = 2'b00;
        #1;
        checks++;
        if (ctl !== 4'b0010) begin
            errors++; $display("FAIL rdr_wait_c2: got %b expected 0010", ctl);
        end
        tick();
        imem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== 4'b0010) begin
            errors++; $display("FAIL rdr_wait_c3: got %b expected 0010", ctl);
        end
        tick();
        #1;
        checks++;
        if (ctl !== 4'b1000) begin
            errors++; $display("FAIL rdr_wait_run: got %b expected 1000", ctl);
        end
    endtask

    task automatic test_reset_and_clk_en();
        set_idle();
        imem_ready = 1'b0; pc_src_e = 2'b10;
        #1;
        tick();
        pc_src_e = 2'b00;
        #1;
        checks++;
        if (ctl !== 4'b0010) begin
            errors++; $display("FAIL wf_before_reset: got %b expected 0010", ctl);
        end
        rst = 1'b1;
        model_async_reset();
        #1;
        checks++;
        if (obs !== 8'b1000_0000) begin
            errors++; $display("FAIL wf_async_reset: got %b expected %b", obs, 8'b1000_0000);
        end
        rst = 1'b0; imem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== 4'b1000) begin
            errors++; $display("FAIL wf_reset_to_run: got %b expected 1000", ctl);
        end
        tick();
        imem_ready = 1'b0; pc_src_e = 2'b01;
        #1;
        tick();
        clk_en = 1'b0; pc_src_e = 2'b00; imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== 4'b0010) begin
                errors++; $display("FAIL clk_en_frozen%0d: got %b expected 0010", i, ctl);
            end
            tick();
        end
        clk_en = 1'b1;
        #1;
        tick();
        #1;
        checks++;
        if (ctl !== 4'b1000) begin
            errors++; $display("FAIL clk_en_resume: got %b expected 1000", ctl);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 39) == 0);
            clk_en       = ($urandom_range(0, 7) != 0);
            imem_ready   = ($urandom_range(0, 3) != 0);
            pc_src_e     = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            result_src_e = 2'($urandom);
            rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
            rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
            rd_e  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
            rd_w  = 5'($urandom_range(0, 3));
            reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
            #1;
            checks++;
            if (obs !== ref_all()) begin
                errors++; $display("FAIL random_cycle%0d: got %b expected %b", i, obs, ref_all());
            end
`ifdef HAZARD_CTL_PERF_EN
            checks++;
            if (stall_cnt !== m_stall_cnt || flush_cnt !== m_flush_cnt) begin
                errors++; $display("FAIL random_counters%0d: got %0d/%0d expected %0d/%0d",
                                   i, stall_cnt, flush_cnt, m_stall_cnt, m_flush_cnt);
            end
`endif
            tick();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        tick();
        test_reset();
        test_forwarding();
        test_load_use();
        test_fetch_wait();
        test_redirect_in_wait();
        test_reset_and_clk_en();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
